spi_exe_master: RTL and testbench

- SPI master that drives the exe-unit SPI slave and consumes its reply; sits directly upstream of it on the shared i_sclk domain.
- Accepts a parallel command (argA, argB, 4-bit opcode) on a valid/ready port. Serialises a 24-bit request frame on o_mosi with o_cs low.
- Captures the 28-bit reply (result, flags, 16 zero pad bits) from i_miso and presents it on a valid/ready response port.

---
 rtl/spi_exe_master.sv | 146 ++++++++++++++
 tb/tb_spi_exe_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_exe_master.sv
// SPI master for the exe-unit slave: serialises {argA, argB, oper, 0} MSB first,
// waits TURNAROUND cycles, captures the RESP_W-bit reply and holds it on a valid/ready port.
module spi_exe_master #(
  parameter int DATA_W     = 8,
  parameter int RESP_W     = 28,
  parameter int TURNAROUND = 2
) (
  input  logic              i_sclk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [DATA_W-1:0] i_argA,
  input  logic [DATA_W-1:0] i_argB,
  input  logic [3:0]        i_oper,
  output logic              o_cs,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_result,
  output logic [3:0]        o_flags,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam int REQ_W   = 3 * DATA_W;
  localparam int PAD_W   = RESP_W - DATA_W - 4;
  localparam int CNT_MAX = (RESP_W > REQ_W) ? RESP_W : REQ_W;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    TURN,
    RECV,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [REQ_W-1:0]    tx_q, tx_d;
  logic [RESP_W-1:0]   rx_q, rx_d;
  logic                mosi_q, mosi_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [3:0]          flags_q, flags_d;
  logic                frame_err_q, frame_err_d;

  logic [REQ_W-1:0]    req_frame;
  logic [RESP_W-1:0]   rx_next;

  assign req_frame = {i_argA, i_argB, i_oper, {(DATA_W-4){1'b0}}};
  assign rx_next   = {rx_q[RESP_W-2:0], i_miso};

  // o_mosi is registered, so SEND covers only REQ_W-1 edges: the accept edge
  // already launches the first bit and the last bit is launched on the SEND->TURN edge.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    mosi_d      = mosi_q;
    result_d    = result_q;
    flags_d     = flags_q;
    frame_err_d = frame_err_q;

    unique case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          tx_d    = {req_frame[REQ_W-2:0], 1'b0};
          mosi_d  = req_frame[REQ_W-1];
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        mosi_d = tx_q[REQ_W-1];
        tx_d   = {tx_q[REQ_W-2:0], 1'b0};
        if (cnt_q == CNT_W'(REQ_W - 2)) begin
          cnt_d   = '0;
          state_d = TURN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TURN: begin
        mosi_d = 1'b0;
        if (cnt_q == CNT_W'(TURNAROUND - 1)) begin
          cnt_d   = '0;
          state_d = RECV;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RECV: begin
        rx_d = rx_next;
        if (cnt_q == CNT_W'(RESP_W - 1)) begin
          result_d    = rx_next[RESP_W-1 -: DATA_W];
          flags_d     = rx_next[RESP_W-DATA_W-1 -: 4];
          frame_err_d = |rx_next[PAD_W-1:0];
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      mosi_q      <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      mosi_q      <= mosi_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_cs        = !(state_q inside {SEND, TURN, RECV});
  assign o_mosi      = mosi_q;
  assign o_cmd_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == DONE);
  assign o_busy      = (state_q != IDLE);
  assign o_result    = result_q;
  assign o_flags     = flags_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_exe_master.sv
// Bench for spi_exe_master: a TURNAROUND=2 and a TURNAROUND=5 instance, each driven by
// a bit-level slave model that records the request and plays back a chosen reply.
module tb_spi_exe_master;

  logic       clk;
  logic       rst_n     [2];
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic [7:0] arg_a     [2];
  logic [7:0] arg_b     [2];
  logic [3:0] oper      [2];
  logic       cs        [2];
  logic       mosi      [2];
  logic       miso      [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] result    [2];
  logic [3:0] flags     [2];
  logic       frame_err [2];
  logic       busy      [2];

  logic [27:0] reply   [2];
  logic [23:0] req_cap [2];
  int          e       [2];
  bit          active  [2];
  int          n_acc   [2] = '{0, 0};

  int checks = 0;
  int passes = 0;

  spi_exe_master #(.DATA_W(8), .RESP_W(28), .TURNAROUND(2)) u_dut_t2 (
    .i_sclk(clk), .i_rst(rst_n[0]), .i_cmd_valid(cmd_valid[0]), .o_cmd_ready(cmd_ready[0]),
    .i_argA(arg_a[0]), .i_argB(arg_b[0]), .i_oper(oper[0]), .o_cs(cs[0]), .o_mosi(mosi[0]),
    .i_miso(miso[0]), .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_result(result[0]), .o_flags(flags[0]), .o_frame_err(frame_err[0]), .o_busy(busy[0])
  );

  spi_exe_master #(.DATA_W(8), .RESP_W(28), .TURNAROUND(5)) u_dut_t5 (
    .i_sclk(clk), .i_rst(rst_n[1]), .i_cmd_valid(cmd_valid[1]), .o_cmd_ready(cmd_ready[1]),
    .i_argA(arg_a[1]), .i_argB(arg_b[1]), .i_oper(oper[1]), .o_cs(cs[1]), .o_mosi(mosi[1]),
    .i_miso(miso[1]), .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_result(result[1]), .o_flags(flags[1]), .o_frame_err(frame_err[1]), .o_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int turn_of(input int d);
    return (d == 1) ? 5 : 2;
  endfunction

  // Slave model, counting edges from the accept edge E0: request bit 23-k is on the
  // wire between E(k) and E(k+1); reply bit 27-j must be stable at edge E(24+T+j).
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        active[d] <= 1'b0;
        e[d]      <= 0;
        miso[d]   <= 1'b0;
      end else if (cmd_valid[d] && cmd_ready[d]) begin
        active[d] <= 1'b1;
        e[d]      <= 0;
        miso[d]   <= 1'b0;
        n_acc[d]  <= n_acc[d] + 1;
      end else if (active[d]) begin
        e[d] <= e[d] + 1;
        if (e[d] <= 23) req_cap[d][5'(23 - e[d])] <= mosi[d];
        if (e[d] >= 22 + turn_of(d) && e[d] <= 49 + turn_of(d))
          miso[d] <= reply[d][5'(49 + turn_of(d) - e[d])];
        else
          miso[d] <= 1'b0;
      end
    end
  end

  task automatic start_cmd(input int d, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input bit keep);
    int n;
    @(negedge clk);
    arg_a[d] = a; arg_b[d] = b; oper[d] = op; cmd_valid[d] = 1'b1;
    n = 0;
    while (cmd_ready[d] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready[d] !== 1'b1) $display("FAIL accept_wait dut%0d: cmd_ready=%b required 1", d, cmd_ready[d]);
    else passes++;
    @(posedge clk);
    @(negedge clk);
    if (!keep) cmd_valid[d] = 1'b0;
  endtask

  // Entered at the negedge after the accept edge; ends at the negedge after the handshake.
  task automatic finish_cmd(input int d, input logic [23:0] exp_frame, input logic [27:0] rep,
                            input int hold, input bit pulse, input bit keep);
    int n;
    bit cs_bad, mosi_bad, stable;
    logic [7:0] exp_res;
    logic [3:0] exp_flg;
    logic       exp_err;
    logic [14:0] snap;
    exp_res = rep[27:20];
    exp_flg = rep[19:16];
    exp_err = (rep[15:0] != 16'h0);
    n = 0; cs_bad = 0; mosi_bad = 0;
    checks++;
    if (cs[d] !== 1'b0) $display("FAIL cs_after_accept dut%0d: cs=%b required 0", d, cs[d]);
    else passes++;
    while (rsp_valid[d] !== 1'b1 && n < 200) begin
      if (pulse) cmd_valid[d] = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      if (rsp_valid[d] !== 1'b1) begin
        if (cs[d] !== 1'b0 || cmd_ready[d] !== 1'b0) cs_bad = 1;
        if (n >= 24 && mosi[d] !== 1'b0) mosi_bad = 1;
      end
    end
    cmd_valid[d] = keep;
    checks++;
    if (n != 51 + turn_of(d)) $display("FAIL latency dut%0d: edges=%0d required %0d", d, n, 51 + turn_of(d));
    else passes++;
    checks++;
    if (cs_bad) $display("FAIL cs_ready_in_frame dut%0d: cs high or cmd_ready during frame, required cs=0 ready=0", d);
    else passes++;
    checks++;
    if (mosi_bad) $display("FAIL mosi_idle dut%0d: mosi=1 after last request bit, required 0", d);
    else passes++;
    checks++;
    if (req_cap[d] !== exp_frame) $display("FAIL request dut%0d: frame=%h required %h", d, req_cap[d], exp_frame);
    else passes++;
    checks++;
    if ({result[d], flags[d], frame_err[d]} !== {exp_res, exp_flg, exp_err})
      $display("FAIL response dut%0d: res=%h flg=%h err=%b required res=%h flg=%h err=%b",
               d, result[d], flags[d], frame_err[d], exp_res, exp_flg, exp_err);
    else passes++;
    checks++;
    if (cs[d] !== 1'b1 || cmd_ready[d] !== 1'b0 || busy[d] !== 1'b1)
      $display("FAIL done_ctrl dut%0d: cs=%b ready=%b busy=%b required 1 0 1", d, cs[d], cmd_ready[d], busy[d]);
    else passes++;
    snap = {result[d], flags[d], frame_err[d], rsp_valid[d], cs[d]};
    stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if ({result[d], flags[d], frame_err[d], rsp_valid[d], cs[d]} !== snap || cmd_ready[d] !== 1'b0)
        stable = 0;
    end
    if (hold > 0) begin
      checks++;
      if (!stable) $display("FAIL backpressure dut%0d: outputs moved while rsp_ready=0, required stable", d);
      else passes++;
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    checks++;
    if (rsp_valid[d] !== 1'b0 || cmd_ready[d] !== 1'b1 || cs[d] !== 1'b1 || result[d] !== exp_res)
      $display("FAIL handshake dut%0d: valid=%b ready=%b cs=%b res=%h required 0 1 1 %h",
               d, rsp_valid[d], cmd_ready[d], cs[d], result[d], exp_res);
    else passes++;
  endtask

  task automatic run_txn(input int d, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [27:0] rep, input int hold, input bit pulse);
    int acc0;
    acc0 = n_acc[d];
    reply[d] = rep;
    start_cmd(d, a, b, op, 1'b0);
    finish_cmd(d, {a, b, op, 4'h0}, rep, hold, pulse, 1'b0);
    checks++;
    if (n_acc[d] != acc0 + 1) $display("FAIL accept_count dut%0d: accepts=%0d required %0d", d, n_acc[d] - acc0, 1);
    else passes++;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({cs[d], mosi[d], cmd_ready[d], rsp_valid[d], busy[d], frame_err[d], flags[d], result[d]} !== {5'b10100, 1'b0, 4'h0, 8'h00})
        $display("FAIL reset_state dut%0d: cs=%b mosi=%b ready=%b valid=%b busy=%b err=%b flg=%h res=%h required cs=1 ready=1 rest 0",
                 d, cs[d], mosi[d], cmd_ready[d], rsp_valid[d], busy[d], frame_err[d], flags[d], result[d]);
      else passes++;
    end
  endtask

  task automatic test_basic_add;
    run_txn(0, 8'h05, 8'h03, 4'h1, 28'h0800000, 0, 1'b0);
  endtask

  task automatic test_flags_pad;
    run_txn(0, 8'($urandom), 8'($urandom), 4'($urandom), {8'hFF, 4'b1010, 16'h0001}, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_txn(0, 8'h7A, 8'h11, 4'h3, {8'h42, 4'h5, 16'h0000}, 10, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [27:0] rep2;
    int acc0;
    acc0 = n_acc[0];
    reply[0] = {8'h99, 4'h3, 16'h0000};
    start_cmd(0, 8'h12, 8'h34, 4'h9, 1'b1);
    arg_a[0] = 8'hC3; arg_b[0] = 8'h3C; oper[0] = 4'hE;
    finish_cmd(0, 24'h123490, {8'h99, 4'h3, 16'h0000}, 0, 1'b0, 1'b1);
    rep2 = {8'($urandom), 4'($urandom), 16'h0000};
    reply[0] = rep2;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    checks++;
    if (cs[0] !== 1'b0 || cmd_ready[0] !== 1'b0 || n_acc[0] != acc0 + 2)
      $display("FAIL b2b_accept: cs=%b ready=%b accepts=%0d required 0 0 %0d", cs[0], cmd_ready[0], n_acc[0] - acc0, 2);
    else passes++;
    finish_cmd(0, 24'hC33CE0, rep2, 0, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse_check(input string name);
    @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    checks++;
    if ({cs[0], mosi[0], rsp_valid[0], result[0], busy[0]} !== {3'b100, 8'h00, 1'b0})
      $display("FAIL %s: cs=%b mosi=%b valid=%b res=%h busy=%b required 1 0 0 00 0",
               name, cs[0], mosi[0], rsp_valid[0], result[0], busy[0]);
    else passes++;
    @(negedge clk);
    rst_n[0] = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    reply[0] = 28'hFFFFFFF;
    start_cmd(0, 8'hAA, 8'h55, 4'hF, 1'b0);
    repeat (10) @(negedge clk);
    reset_pulse_check("reset_mid_send");
    run_txn(0, 8'h5A, 8'hA5, 4'h6, {8'h3C, 4'h6, 16'h0000}, 0, 1'b0);
    reply[0] = 28'hFFFFFFF;
    start_cmd(0, 8'h01, 8'h02, 4'h4, 1'b0);
    repeat (35) @(negedge clk);
    reset_pulse_check("reset_mid_recv");
    run_txn(0, 8'hE7, 8'h18, 4'h2, {8'h81, 4'h9, 16'h8000}, 1, 1'b0);
  endtask

  task automatic test_turnaround5;
    run_txn(1, 8'h05, 8'h03, 4'h1, 28'h0800000, 0, 1'b1);
    run_txn(1, 8'($urandom), 8'($urandom), 4'($urandom), {8'hFF, 4'b1010, 16'h0001}, 2, 1'b1);
  endtask

  task automatic test_random;
    logic [27:0] rep;
    int d;
    for (int i = 0; i < 16; i++) begin
      d = int'($urandom_range(0, 1));
      rep = 28'($urandom);
      if ($urandom_range(0, 1) == 1) rep[15:0] = 16'h0;
      run_txn(d, 8'($urandom), 8'($urandom), 4'($urandom), rep, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; cmd_valid[d] = 1'b0; rsp_ready[d] = 1'b0;
      arg_a[d] = '0; arg_b[d] = '0; oper[d] = '0; reply[d] = '0;
    end
    #1;
    test_reset;
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    test_basic_add;
    test_flags_pad;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_frame;
    test_turnaround5;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
